// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with a 2-entry skid buffer carrying a control field and an opaque payload.
// Latency 1 cycle; in_ready is registered (deasserts only when both entries hold data), throughput 1/cycle.
// Optional trace of handshakes and flushes is enabled by defining PIPE_STAGE_HS_TRACE_EN.
module pipe_stage_hs #(
    parameter int DATA_W   = 128,
    parameter int CTRL_W   = 32,
    parameter int STAGE_ID = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, main_nxt, skid_nxt, incoming;
    logic   in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign incoming = '{ctrl: in_ctrl, data: in_data};

    assign out_ctrl = main_q.ctrl;
    assign out_data = main_q.data;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // A same-cycle input is dropped; both entries are discarded.
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_nxt  = incoming;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_nxt = incoming;
                    end else if (in_fire) begin
                        skid_nxt  = incoming;
                        state_nxt = FULL;
                    end else if (out_fire) begin
                        main_nxt  = '0;
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                        state_nxt = BUSY;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // Flags are registered from the next state so no output depends combinationally on inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_q    <= main_nxt;
            skid_q    <= skid_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            occupancy <= state_nxt;
        end
    end

`ifdef PIPE_STAGE_HS_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && out_fire) begin
            $display("stage %0d out ctrl=%h data=%h", STAGE_ID, out_ctrl, out_data);
        end
        if (rst && flush) begin
            $display("stage %0d flush occ=%0d", STAGE_ID, occupancy);
        end
    end
`else
    logic unused_stage_id;
    assign unused_stage_id = (STAGE_ID != 0);
`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: vector table of per-cycle inputs/expected outputs plus async-reset sequence.
module tb_pipe_stage_hs;
    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ov;
        logic          ir;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        logic [1:0]    occ;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .STAGE_ID(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [CW-1:0] ic,
                                input logic [DW-1:0] id, input logic ordy, input logic ov,
                                input logic ir, input logic [CW-1:0] oc, input logic [DW-1:0] od,
                                input logic [1:0] occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.oc = oc; v.od = od; v.occ = occ;
        return v;
    endfunction

    task automatic drive(input logic fl, input logic iv, input logic [CW-1:0] ic,
                         input logic [DW-1:0] id, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0);

        // Single transfer, then drain (idle inputs carry X to prove they never propagate).
        vecs.push_back(mk(0, 1, 8'h15, 16'h1000, 1, 1, 1, 8'h15, 16'h1000, 2'd1));
        vecs.push_back(mk(0, 0, 'x,    'x,       1, 0, 1, 8'h00, 16'h0000, 2'd0));
        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(0, 1, CW'(8'h20 + i), DW'(i), 1, 1, 1, CW'(8'h20 + i), DW'(i), 2'd1));
        end
        vecs.push_back(mk(0, 0, 'x, 'x, 1, 0, 1, 8'h00, 16'h0000, 2'd0));
        // Backpressure: A, B fill the stage; C is refused until a slot frees.
        vecs.push_back(mk(0, 1, 8'hA1, 16'h000A, 0, 1, 1, 8'hA1, 16'h000A, 2'd1));
        vecs.push_back(mk(0, 1, 8'hB1, 16'h000B, 0, 1, 0, 8'hA1, 16'h000A, 2'd2));
        vecs.push_back(mk(0, 1, 8'hC1, 16'h000C, 0, 1, 0, 8'hA1, 16'h000A, 2'd2));
        vecs.push_back(mk(0, 1, 8'hC1, 16'h000C, 1, 1, 1, 8'hB1, 16'h000B, 2'd1));
        vecs.push_back(mk(0, 1, 8'hC1, 16'h000C, 1, 1, 1, 8'hC1, 16'h000C, 2'd1));
        vecs.push_back(mk(0, 0, 'x,    'x,       1, 0, 1, 8'h00, 16'h0000, 2'd0));
        // Flush while FULL with D offered: everything discarded, D never shows.
        vecs.push_back(mk(0, 1, 8'hE1, 16'h000E, 0, 1, 1, 8'hE1, 16'h000E, 2'd1));
        vecs.push_back(mk(0, 1, 8'hF1, 16'h000F, 0, 1, 0, 8'hE1, 16'h000E, 2'd2));
        vecs.push_back(mk(1, 1, 8'hD1, 16'h000D, 0, 0, 1, 8'h00, 16'h0000, 2'd0));
        vecs.push_back(mk(0, 0, 'x,    'x,       1, 0, 1, 8'h00, 16'h0000, 2'd0));
        // Bubble mid-stream: head 0x12 lost, stream resumes with 0x13.
        vecs.push_back(mk(0, 1, 8'h51, 16'h0011, 1, 1, 1, 8'h51, 16'h0011, 2'd1));
        vecs.push_back(mk(0, 1, 8'h52, 16'h0012, 1, 1, 1, 8'h52, 16'h0012, 2'd1));
        vecs.push_back(mk(1, 0, 'x,    'x,       0, 0, 1, 8'h00, 16'h0000, 2'd0));
        vecs.push_back(mk(0, 1, 8'h53, 16'h0013, 1, 1, 1, 8'h53, 16'h0013, 2'd1));
        vecs.push_back(mk(0, 1, 8'h54, 16'h0014, 1, 1, 1, 8'h54, 16'h0014, 2'd1));
        vecs.push_back(mk(0, 0, 'x,    'x,       1, 0, 1, 8'h00, 16'h0000, 2'd0));

        #12;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_occ",       32'(occupancy), 32'd0);
        check("reset_ctrl",      32'(out_ctrl),  32'd0);
        check("reset_data",      32'(out_data),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].fl, vecs[k].iv, vecs[k].ic, vecs[k].id, vecs[k].ordy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].ov));
            check($sformatf("v%0d_in_ready", k),  32'(in_ready),  32'(vecs[k].ir));
            check($sformatf("v%0d_ctrl", k),      32'(out_ctrl),  32'(vecs[k].oc));
            check($sformatf("v%0d_data", k),      32'(out_data),  32'(vecs[k].od));
            check($sformatf("v%0d_occ", k),       32'(occupancy), 32'(vecs[k].occ));
        end

        // Asynchronous reset between edges while FULL.
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h61, 16'h0061, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 8'h62, 16'h0062, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 'x, 'x, 1'b0);
        check("pre_areset_occ", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_in_ready",  32'(in_ready),  32'd1);
        check("areset_occ",       32'(occupancy), 32'd0);
        check("areset_data",      32'(out_data),  32'd0);
        check("areset_ctrl",      32'(out_ctrl),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 8'h77, 16'h0777, 1'b1);
        @(posedge clk);
        #1;
        check("post_reset_valid", 32'(out_valid), 32'd1);
        check("post_reset_data",  32'(out_data),  32'h0777);
        check("post_reset_ctrl",  32'(out_ctrl),  32'h77);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1;
        check("post_reset_drain", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline-stage register, successor to the fixed-field ID/EX register.
- Carries an opaque data payload and a control field between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer, so upstream ready is registered and throughput is 1 transfer/cycle.
- Flush inserts a bubble: control field and data both zero.
- Instantiated between ID/EX, EX/MEM and MEM/WB with different widths.

Parameters:
- DATA_W, 128, payload width (packed pc/rs1 data/rs2 data/imm for ID/EX); must be >= 1.
- CTRL_W, 32, control-field width (rd, rs1, rs2, alu_op, mem/branch/write-enable bits); must be >= 1.
- STAGE_ID, 0, integer tag used only by the optional trace.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- flush  input  1  synchronous flush; empties the stage.
- in_valid  input  1  upstream offers in_ctrl/in_data.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  upstream control field.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  stage holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  control field of head entry.
- out_data  output  DATA_W  payload of head entry.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Firing conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives the outputs) and skid register.
- States and flags:
  - EMPTY(occ 0), BUSY(occ 1), FULL(occ 2).
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - All outputs come directly from flops, with no combinational in-to-out paths.
- Reset (rst=0, async): state EMPTY, main=0, skid=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Reset release: first accepted input on the following edge.
- Transitions when flush=0:
  - EMPTY: in_fire -> main<=in, BUSY. Otherwise stay.
  - BUSY:
    - in_fire & out_fire -> main<=in, stay BUSY.
    - in_fire & !out_fire -> skid<=in, FULL.
    - !in_fire & out_fire -> main<=0, EMPTY.
    - Otherwise hold.
  - FULL: out_fire -> main<=skid, skid<=0, BUSY. Otherwise hold. in_ready=0, so no input is taken.
- Invariant: out_ctrl=0 and out_data=0 whenever out_valid=0, so a bubble decodes as a NOP.
- Latency: in_fire in cycle N -> out_valid and data visible in cycle N+1 (EMPTY, or BUSY with out_fire).
- Ordering: strict FIFO; the skid entry is never bypassed.
- Flush (flush=1 at edge):
  - Next state EMPTY; main, skid and outputs cleared to 0; in_ready=1 next cycle.
  - Flush overrides a same-cycle in_fire: that input is dropped and upstream must treat it as consumed.
  - A same-cycle out_fire is still a valid consumption of the current head.
- Flush while FULL: both entries are discarded.
- Holding: out_valid=1 with out_ready=0 holds out_ctrl/out_data stable until out_fire or flush. X on in_* while in_valid=0 never propagates.
- Reset mid-operation: all entries are lost immediately on rst falling, regardless of clk.

Optional Feature:
- Macro: PIPE_STAGE_HS_TRACE_EN.
- When defined: each out_fire edge executes $display("stage %0d out ctrl=%h data=%h", STAGE_ID, out_ctrl, out_data); each flush edge executes $display("stage %0d flush occ=%0d", STAGE_ID, occupancy).
- When undefined: no system tasks are present; functional behaviour is identical.

Test Plan:
- Reset and single transfer: rst=0 then 1; in_valid=1, ctrl=0x15, data=0x1000 for one cycle, out_ready=1 -> next cycle out_valid=1, ctrl=0x15, data=0x1000; cycle after, out_valid=0, out_ctrl=0, occupancy=0.
- Streaming: in_valid=1 with data 1..8 on consecutive cycles, out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready constantly 1, occupancy 1.
- Backpressure: send A=0xA, B=0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; C offered is not accepted; raise out_ready -> 0xA, 0xB, then C in order.
- Flush: state FULL with in_valid=1 (D=0xD) and flush=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1; 0xD never appears.
- Async reset: assert rst=0 between clk edges while occupancy=2 -> out_valid=0 and in_ready=1 immediately, before the next edge.
- Bubble: flush for one cycle in the middle of the streaming test -> exactly the entry at the head is lost; subsequent values resume in order with out_ctrl=0 during the gap.
